// File: rtl/eq_seq_ctrl_pkg.sv
// Shared definitions for the sequential slice-by-slice equality comparator.
package eq_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 2;
    localparam int NSL_W     = 5;

    // Number of slices an operand of width w splits into.
    function automatic int slice_count(input int w, input int s);
        return w / s;
    endfunction

endpackage

// File: rtl/eq_seq_ctrl_if.sv
// Request/result bundle between a requester and the equality comparator.
interface eq_seq_ctrl_if
    import eq_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic [NSL_W-1:0] nslices;

    modport master (
        output start, a, b,
        input  busy, done, eq, nslices
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, nslices
    );

endinterface

// File: rtl/eq_seq_ctrl_eq_slice.sv
// Combinational equality of one operand slice.
module eq_slice #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             y
);

    assign y = (a == b);

endmodule

// File: rtl/eq_seq_ctrl.sv
// Sequential equality comparator: walks the captured operands one slice per
// cycle from the LSB, stopping early at the first differing slice.
module eq_seq_ctrl
    import eq_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input logic          clk,
    input logic          rst,
    eq_seq_ctrl_if.slave bus
);

    localparam int NSL   = slice_count(WIDTH, SLICE);
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             eq_q;
    logic [NSL_W-1:0] nsl_q;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic             slice_eq;
    logic             accept;
    logic             step;
    logic             last;

    assign a_sl = a_q[int'(idx) * SLICE +: SLICE];
    assign b_sl = b_q[int'(idx) * SLICE +: SLICE];
    assign last = (idx == LAST_IDX);

    eq_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a (a_sl),
        .b (b_sl),
        .y (slice_eq)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (!slice_eq || last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A mismatch or the final matching slice freezes idx; eq/nslices then hold until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            eq_q  <= 1'b0;
            nsl_q <= '0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            idx   <= '0;
            eq_q  <= 1'b0;
            nsl_q <= '0;
        end else if (step) begin
            nsl_q <= nsl_q + NSL_W'(1);
            if (!slice_eq) begin
                eq_q <= 1'b0;
            end else if (last) begin
                eq_q <= 1'b1;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.eq      = eq_q;
    assign bus.nslices = nsl_q;

endmodule
